// File: rtl/shared_adder_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shared_adder_arbiter_pkg
//   Shared constants and helpers for the shared-adder arbiter slice.
//   DATA_W : operand width (signed)
//   SUM_W  : full-precision sum width (one growth bit, never saturates)
//   rr_pick(valid, ptr, nreq) : round-robin search starting at ptr; returns
//            the first valid index at or after ptr (mod nreq) plus an any flag.
// ---------------------------------------------------------------------------
package shared_adder_arbiter_pkg;

  localparam int DATA_W   = 16;
  localparam int SUM_W    = DATA_W + 1;
  localparam int MAX_NREQ = 16;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_pick_t;

  // Vectors are sized for the largest legal requester count; callers
  // zero-extend their narrower valid vector and pointer.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [3:0]          ptr,
                                       input int                  nreq);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < nreq && !r.any) begin
        // ptr < nreq and k < nreq, so one conditional subtract is the modulo.
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (valid[4'(j)]) begin
          r.any = 1'b1;
          r.idx = 4'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_adder_arbiter_if
//   Request and response bundle of the shared adder arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : signed operands, requester i in bits [16i+15:16i]
//   resp_valid/ready    : registered response handshake with backpressure
//   resp_sum            : 17-bit signed sum, resp_id : producing requester
//   Modports: master = requesters + downstream, slave = the arbiter.
// ---------------------------------------------------------------------------
interface shared_adder_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import shared_adder_arbiter_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [SUM_W-1:0]       resp_sum;
  logic [IDW-1:0]         resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_id
  );

endinterface

// File: rtl/shared_adder_arbiter_adder.sv
// ---------------------------------------------------------------------------
// adder
//   Purely combinational signed adder shared by all requesters.
//   a, b : signed DATA_W operands
//   sum  : sign-extended SUM_W result, full precision (cannot overflow)
// ---------------------------------------------------------------------------
module adder
  import shared_adder_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [SUM_W-1:0]  sum
);

  assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};

endmodule

// File: rtl/shared_adder_arbiter.sv
// ---------------------------------------------------------------------------
// shared_adder_arbiter
//   Round-robin arbiter sharing one signed adder among NREQ requesters,
//   followed by a single registered response stage (1-cycle latency,
//   full throughput, backpressure via resp_ready).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave modport of shared_adder_arbiter_if (requests + response)
// ---------------------------------------------------------------------------
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  shared_adder_arbiter_if.slave        bus
);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    next_ptr;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic [SUM_W-1:0]  sum;
  logic [NREQ-1:0]   ready;
  logic              can_load;
  logic              accept;
  rr_pick_t          pick;

  logic              resp_valid_q;
  logic [SUM_W-1:0]  resp_sum_q;
  logic [IDW-1:0]    resp_id_q;

  // The response register may take a new result when it is empty or its
  // current content leaves on this edge.
  assign can_load = ~resp_valid_q | bus.resp_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no
    // path through the loop leaves it unassigned and infers a latch.
    winner   = '0;
    next_ptr = '0;
    win_a    = '0;
    win_b    = '0;
    pick     = rr_pick(MAX_NREQ'(bus.req_valid), 4'(ptr), NREQ);
    // Decode the pick into the local index width and select the operands.
    for (int i = 0; i < NREQ; i++) begin
      if (pick.idx == 4'(i)) begin
        winner   = IDW'(i);
        next_ptr = (i == NREQ - 1) ? '0 : IDW'(i + 1);
        win_a    = bus.req_a[i*DATA_W +: DATA_W];
        win_b    = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (rst_n && can_load && pick.any) ready[winner] = 1'b1;
  end

  assign accept = pick.any & can_load & rst_n;

  adder u_adder (
    .a   (win_a),
    .b   (win_b),
    .sum (sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well because the reset
      // values of resp_sum/resp_id are observable on the port.
      ptr          <= '0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_id_q    <= '0;
    end else if (accept) begin
      // A simultaneous transfer is covered here: the new result simply
      // overwrites the leaving one and resp_valid stays high.
      resp_valid_q <= 1'b1;
      resp_sum_q   <= sum;
      resp_id_q    <= winner;
      ptr          <= next_ptr;
    end else if (resp_valid_q && bus.resp_ready) begin
      // Drained with nothing to replace it; sum/id keep stale values.
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_id    = resp_id_q;

endmodule

// File: doc/shared_adder_arbiter.md
# shared_adder_arbiter

Round-robin arbiter and output stage that shares one signed 16-bit adder among `NREQ` requesters, such as neuron partial-sum units in the ANN datapath. Each requester offers an operand pair with a valid/ready handshake. The block grants one request per cycle, computes the full-precision 17-bit sum, and returns it through a single registered response port that carries the requester index and supports backpressure. It sits between the neuron accumulation logic and the shared adder instance.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters. Legal range is 2..16.
- `IDW`, default 2: width of the requester index. Must equal ceil(log2(NREQ)).

Ports:
- `clk`, in, 1: the only clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `req_valid`, in, NREQ: per-requester valid.
- `req_a`, in, NREQ*16: signed operand a. Requester i occupies bits [16i+15:16i].
- `req_b`, in, NREQ*16: signed operand b. Same packing as `req_a`.
- `req_ready`, out, NREQ: per-requester ready. One-hot or zero.
- `resp_valid`, out, 1: the response register holds a result.
- `resp_ready`, in, 1: the downstream stage accepts the response.
- `resp_sum`, out, 17: signed sum a+b, sign-extended, never saturated.
- `resp_id`, out, IDW: index of the requester that produced `resp_sum`.

## Operation
Handshakes:
- A request from requester i is accepted on a rising edge where `req_valid[i] & req_ready[i]`.
- A requester must hold `req_valid` and its operands stable until accepted.
- A response transfers on an edge where `resp_valid & resp_ready`.

Stage and grant logic:
- `can_load = ~resp_valid | resp_ready`. This means the output register is empty or draining this cycle.
- Grant search is round-robin. Start at pointer `ptr` and scan indices ptr, ptr+1, … modulo NREQ. The first index with `req_valid` set wins.
- `req_ready[i] = can_load & (i == winner) & any_valid`. Readiness is combinational from `req_valid`, `ptr`, `resp_valid` and `resp_ready`.
- On acceptance of winner w:
  - `resp_sum` and `resp_id` load `sext(a_w) + sext(b_w)` and `w`.
  - `resp_valid` goes to 1.
  - `ptr` becomes (w+1) mod NREQ, wrapping from NREQ-1 to 0.
- If a response transfers and no request is accepted, `resp_valid` goes to 0. `resp_sum` and `resp_id` hold their stale values.
- If a transfer and an acceptance happen on the same edge, the new result replaces the old one and `resp_valid` stays 1. This gives full throughput of one sum per cycle.
- `ptr` does not move when nothing is accepted.

Arithmetic and safety:
- Full-precision two's-complement arithmetic. Range is -65536..65534. No overflow is possible.
- At most one `req_ready` bit is high in any cycle. A requester that is valid is granted within NREQ accepted transfers, so there is no starvation.

Reset:
- When `rst_n`=0 at an edge: `ptr`=0, `resp_valid`=0, `resp_sum`=0, `resp_id`=0.
- While `rst_n`=0, `req_ready` is forced to all-zero.
- Reset mid-transfer discards the pending response with no output pulse.

## Timing
- Latency is 1 cycle. A request accepted at edge T appears with `resp_valid`=1 after T and can transfer at edge T+1 at the earliest.
- Throughput is 1 accepted request per cycle while `resp_ready`=1.
- With `resp_ready`=0 and `resp_valid`=1, all `req_ready` bits are 0 and the response holds stable.
- The first edge with `rst_n`=1 can already accept a request.
- There is no combinational path from `req_*` to `resp_*`. The only combinational path from `resp_ready` is to `req_ready`.

## Structure
- A shared package holds:
  - `DATA_W`=16 and `SUM_W`=DATA_W+1.
  - A function `rr_pick(valid, ptr)` that returns the winner index and an `any` flag.
- Natural sub-module: instantiate the team's existing 16-bit signed `adder` on the muxed winner operands. Its 17-bit output feeds the response register.
- The arbitration mux and the pointer stay in this block.

## Test plan
1. Reset: hold `rst_n`=0 for 2 cycles with all `req_valid`=1. Expect `req_ready`=0, `resp_valid`=0, `resp_sum`=0 and `resp_id`=0 throughout.
2. Single request: requester 2 offers a=100, b=-300 with `resp_ready`=1. It is accepted on the first edge. The next cycle shows `resp_valid`=1, `resp_sum`=-200 (17'h1FF38), `resp_id`=2, and after that `ptr`=3.
3. Extremes:
   - 32767+32767 gives 65534.
   - (-32768)+(-32768) gives -65536 (17'h10000).
   - 32767+(-32768) gives -1.
4. Fairness: all 4 requesters valid continuously with `resp_ready`=1. `resp_id` sequence is 0,1,2,3,0,1…, one result per cycle with no gaps.
5. Backpressure: hold `resp_ready`=0 for 3 cycles while requesters 1 and 3 are valid. The response stays stable and `req_ready`=0. On release, a transfer and an acceptance happen on the same edge, and the next result is from the next index in round-robin order.
6. Reset mid-operation: assert `rst_n`=0 while `resp_valid`=1 and `resp_ready`=0. After reset, `resp_valid`=0 and `ptr`=0, and requester 0 is granted first even if requester 3 is also valid.
